// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and elaboration-time helpers.
// Used by rr_mux and rr_arbiter to size select fields.
package cpu_pkg;

  localparam int CPU_XLEN = 32;

  // Number of bits needed to encode n distinct values; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
// RR_MUX_FIXED_PRIO_EN turns it into a fixed lowest-index-wins arbiter.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [SEL_W-1:0] grant_idx_o
);

  int   start;
  int   idx;
  logic found;

`ifdef RR_MUX_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign start      = 0;
`else
  assign start      = int'(ptr_i);
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = start + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel valid/ready multiplexer with a registered output and round-robin
// arbitration; define RR_MUX_FIXED_PRIO_EN for fixed lowest-index priority.
module rr_mux
  import cpu_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = CPU_XLEN,
  localparam int SEL_W = (clog2(N_CH) > 1) ? clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] ptr_q;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gnt_idx;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i       (in_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gnt_idx)
  );

  // The output slot can take a new beat if empty or draining this cycle.
  assign free     = !out_valid_q || out_ready;
  assign in_ready = free ? grant : '0;
  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [SEL_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_ch_q    <= gnt_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (N_CH=4, WIDTH=8): directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_rr_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;

  rr_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;

  // Producer-side pending beats
  bit         pend[N];
  logic [7:0] pdata[N];
  logic [N-1:0] last_rdy;
  logic [N-1:0] last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int c = 0; c < N; c++) if (v[c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick(in_valid, m_ptr);
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_ch(input int c, input logic v, input logic [7:0] d);
    in_valid[c]      = v;
    in_data[c*W +: W] = d;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [N-1:0] er;
    int g;
    #1;
    er = exp_ready();
    last_rdy = in_ready;
    check("in_ready", in_ready, er);
    last_acc = er & in_valid;
    @(posedge clk);
    if (|er) begin
      g       = pick(in_valid, m_ptr);
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      m_valid = 1;
`ifdef RR_MUX_FIXED_PRIO_EN
      m_ptr   = 0;
`else
      m_ptr   = (g + 1) % N;
`endif
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_ch", out_ch, m_ch);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_inputs();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) begin
        pend[i]  = 1;
        pdata[i] = 8'($urandom);
      end
      set_ch(i, pend[i], pdata[i]);
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic retire_accepted();
    for (int i = 0; i < N; i++) if (last_acc[i]) pend[i] = 0;
  endtask

  initial begin
    int exp_seq[5];
    logic [7:0] held_d;
    logic [1:0] held_c;
    int lo;

    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = 32'($urandom);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 0;
    model_reset();

    // Reset is immediate, before any clock edge
    #2;
    rst_n     = 1'b0;
    out_ready = 1'($urandom);
    #1;
    check("init_valid", out_valid, 0);
    check("init_data", out_data, 8'h00);
    check("init_ch", out_ch, 0);
    check("init_ready", in_ready, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on channel 2
    out_ready = 1'b1;
    set_ch(2, 1'b1, 8'hA5);
    cycle();
    check("single_rdy", last_rdy, 4'b0100);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 8'hA5);
    check("single_ch", out_ch, 2);
    in_valid = '0;
    cycle();
    check("drain_valid", out_valid, 0);

    // Fairness with all channels requesting
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 8'h10 + 8'(c));
`ifdef RR_MUX_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    for (int b = 0; b < 5; b++) begin
      cycle();
      check("fair_valid", out_valid, 1);
      check("fair_ch", out_ch, exp_seq[b]);
      check("fair_data", out_data, 8'h10 + 8'(exp_seq[b]));
    end

    // Backpressure holds the output beat
    held_d    = out_data;
    held_c    = out_ch;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      cycle();
      check("bp_ready", last_rdy, 4'b0000);
      check("bp_data", out_data, held_d);
      check("bp_ch", out_ch, held_c);
    end
    out_ready = 1'b1;
    cycle();
`ifdef RR_MUX_FIXED_PRIO_EN
    check("bp_resume", last_rdy, 4'b0001);
    check("bp_resume_ch", out_ch, 0);
`else
    check("bp_resume", last_rdy, 4'b0010);
    check("bp_resume_ch", out_ch, 1);
`endif

    // Pointer skip over idle channels
    do_reset();
    in_valid = '0;
    set_ch(0, 1'b1, 8'h3C);
    cycle();
    set_ch(3, 1'b1, 8'hC3);
    cycle();
`ifdef RR_MUX_FIXED_PRIO_EN
    check("skip_first", last_rdy, 4'b0001);
`else
    check("skip_first", last_rdy, 4'b1000);
    check("skip_first_ch", out_ch, 3);
`endif
    cycle();
    check("skip_second", last_rdy, 4'b0001);
    check("skip_second_ch", out_ch, 0);

    // Randomized traffic with an asynchronous reset mid-stream
    do_reset();
    in_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int t = 0; t < 400; t++) begin
      random_inputs();
      if (t == 200) begin
        do_reset();
        if (in_valid == '0) begin
          pend[1]  = 1;
          pdata[1] = 8'($urandom);
          set_ch(1, 1'b1, pdata[1]);
        end
        lo = lowest(in_valid);
        cycle();
        check("rst_first_ch", out_ch, lo);
        check("rst_first_valid", out_valid, 1);
      end else begin
        cycle();
      end
      retire_accepted();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
